// File: rtl/fp_round_pkg.sv
// ============================================================================
// Module      : fp_round_pkg
// Description : Shared types and helpers for the FP rounding datapath.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fp_round_pkg;

  typedef enum logic [1:0] {
    RUP   = 2'b00,
    RDOWN = 2'b01,
    RTE   = 2'b10,
    RTAZ  = 2'b11
  } round_mode_t;

  localparam int GRS_W = 3;

  // All-ones biased exponent (inf/NaN encoding) for an exponent of width ew.
  function automatic logic [31:0] EXP_MAX(input int unsigned ew);
    return (32'd1 << ew) - 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_round_decide.sv
// ============================================================================
// Module      : fp_round_decide
// Description : Combinational round-increment and inexact decision.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_round_decide
  import fp_round_pkg::*;
(
  input  logic             sign,
  input  logic             lsb,
  input  logic [GRS_W-1:0] grs,
  input  logic [1:0]       mode,
  output logic             inc,
  output logic             inexact
);

  logic w_g;
  logic w_r;
  logic w_st;
  logic w_any;

  assign w_g     = grs[2];
  assign w_r     = grs[1];
  assign w_st    = grs[0];
  assign w_any   = w_g | w_r | w_st;
  assign inexact = w_any;

  always_comb begin
    inc = 1'b0;
    case (round_mode_t'(mode))
      RUP:     inc = ~sign & w_any;
      RDOWN:   inc = sign & w_any;
      RTE:     inc = w_g & (w_r | w_st | lsb);
      RTAZ:    inc = w_g;
      default: inc = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fp_round_pipe.sv
// ============================================================================
// Module      : fp_round_pipe
// Description : Two-stage pipelined IEEE-754 rounding unit, valid/ready on both sides.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_round_pipe
  import fp_round_pkg::*;
#(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EW-1:0]    in_exp,
  input  logic [MW:0]      in_mant,
  input  logic [GRS_W-1:0] in_grs,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EW-1:0]    out_exp,
  output logic [MW-1:0]    out_frac,
  output logic             out_inexact,
  output logic             out_overflow,
  output logic             out_renorm
);

  localparam logic [EW-1:0] c_exp_max = EW'(EXP_MAX(EW));

  logic            w_adv1;
  logic            w_adv2;
  logic            w_inc;
  logic            w_inexact;
  logic            w_special;
  logic [MW+1:0]   w_sum;

  logic            r1_valid;
  logic [MW+1:0]   r1_sum;
  logic            r1_sign;
  logic [EW-1:0]   r1_exp;
  logic            r1_any;
  logic            r1_special;

  logic [EW:0]     w_exp_inc;
  logic [EW-1:0]   w_exp;
  logic [MW-1:0]   w_frac;
  logic            w_ovf;
  logic            w_ren;

  assign w_adv2   = ~out_valid | out_ready;
  assign w_adv1   = ~r1_valid | w_adv2;
  assign in_ready = w_adv1;

  fp_round_decide u_decide (
    .sign    (in_sign),
    .lsb     (in_mant[0]),
    .grs     (in_grs),
    .mode    (in_mode),
    .inc     (w_inc),
    .inexact (w_inexact)
  );

  // Specials (inf/NaN) bypass rounding entirely.
  assign w_special = (in_exp == c_exp_max);
  assign w_sum     = {1'b0, in_mant} + {{(MW+1){1'b0}}, (w_inc & ~w_special)};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1_valid   <= 1'b0;
      r1_sum     <= '0;
      r1_sign    <= 1'b0;
      r1_exp     <= '0;
      r1_any     <= 1'b0;
      r1_special <= 1'b0;
    end else if (w_adv1) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_sum     <= w_sum;
        r1_sign    <= in_sign;
        r1_exp     <= in_exp;
        r1_any     <= w_inexact & ~w_special;
        r1_special <= w_special;
      end
    end
  end

  assign w_exp_inc = {1'b0, r1_exp} + {{EW{1'b0}}, 1'b1};

  always_comb begin
    w_exp  = r1_exp;
    w_frac = r1_sum[MW-1:0];
    w_ovf  = 1'b0;
    w_ren  = 1'b0;
    if (!r1_special) begin
      if (r1_sum[MW+1]) begin
        w_exp  = w_exp_inc[EW] ? c_exp_max : w_exp_inc[EW-1:0];
        w_frac = '0;
        w_ren  = 1'b1;
      end else if ((r1_exp == '0) && r1_sum[MW]) begin
        w_exp = {{(EW-1){1'b0}}, 1'b1};
        w_ren = 1'b1;
      end
      // Every increment moves toward larger magnitude, so a carry into max exp is inf.
      if (w_exp == c_exp_max) begin
        w_frac = '0;
        w_ovf  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_sign     <= 1'b0;
      out_exp      <= '0;
      out_frac     <= '0;
      out_inexact  <= 1'b0;
      out_overflow <= 1'b0;
      out_renorm   <= 1'b0;
    end else if (w_adv2) begin
      out_valid <= r1_valid;
      if (r1_valid) begin
        out_sign     <= r1_sign;
        out_exp      <= w_exp;
        out_frac     <= w_frac;
        out_inexact  <= r1_any;
        out_overflow <= w_ovf;
        out_renorm   <= w_ren;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_round_pipe.sv
// ============================================================================
// Module      : tb_fp_round_pipe
// Description : Directed self-checking bench for fp_round_pipe (EW=8, MW=23).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp_round_pipe;

  localparam int EW = 8;
  localparam int MW = 23;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_sign;
  logic [EW-1:0] in_exp;
  logic [MW:0]   in_mant;
  logic [2:0]    in_grs;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic          out_sign;
  logic [EW-1:0] out_exp;
  logic [MW-1:0] out_frac;
  logic          out_inexact;
  logic          out_overflow;
  logic          out_renorm;

  // {sign, exp, frac, inexact, overflow, renorm}
  logic [34:0]   obs;
  assign obs = {out_sign, out_exp, out_frac, out_inexact, out_overflow, out_renorm};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_round_pipe #(.EW(EW), .MW(MW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_mant      (in_mant),
    .in_grs       (in_grs),
    .in_mode      (in_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sign     (out_sign),
    .out_exp      (out_exp),
    .out_frac     (out_frac),
    .out_inexact  (out_inexact),
    .out_overflow (out_overflow),
    .out_renorm   (out_renorm)
  );

  task automatic drive(input logic s, input logic [7:0] e, input logic [23:0] m,
                       input logic [2:0] g, input logic [1:0] md);
    in_sign = s;
    in_exp  = e;
    in_mant = m;
    in_grs  = g;
    in_mode = md;
  endtask

  // Sends one item into an empty pipe and captures the result; lat = cycles to out_valid.
  task automatic run_item(input logic s, input logic [7:0] e, input logic [23:0] m,
                          input logic [2:0] g, input logic [1:0] md,
                          output logic [34:0] res, output int lat);
    res = 'x;
    lat = -1;
    drive(s, e, m, g, md);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (out_valid) begin
        res = obs;
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(1'b0, 8'h00, 24'h0, 3'b000, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (obs !== 35'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", obs); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_rte;
    logic [34:0] r; int lat;
    run_item(1'b0, 8'h7F, 24'h800001, 3'b100, 2'b10, r, lat);
    n_cmp++; if (r !== {1'b0, 8'h7F, 23'h000002, 3'b100}) begin n_err++; $display("FAIL rte_tie_odd: got %h want %h", r, {1'b0, 8'h7F, 23'h000002, 3'b100}); end
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL latency: got %0d want 2", lat); end
    run_item(1'b0, 8'h7F, 24'h800002, 3'b100, 2'b10, r, lat);
    n_cmp++; if (r !== {1'b0, 8'h7F, 23'h000002, 3'b100}) begin n_err++; $display("FAIL rte_tie_even: got %h want %h", r, {1'b0, 8'h7F, 23'h000002, 3'b100}); end
  endtask

  task automatic test_carry;
    logic [34:0] r; int lat;
    run_item(1'b0, 8'h80, 24'hFFFFFF, 3'b011, 2'b00, r, lat);
    n_cmp++; if (r !== {1'b0, 8'h81, 23'h0, 3'b101}) begin n_err++; $display("FAIL carry_rup_pos: got %h want %h", r, {1'b0, 8'h81, 23'h0, 3'b101}); end
    run_item(1'b1, 8'h80, 24'hFFFFFF, 3'b011, 2'b00, r, lat);
    n_cmp++; if (r !== {1'b1, 8'h80, 23'h7FFFFF, 3'b100}) begin n_err++; $display("FAIL carry_rup_neg: got %h want %h", r, {1'b1, 8'h80, 23'h7FFFFF, 3'b100}); end
  endtask

  task automatic test_overflow;
    logic [34:0] r; int lat;
    run_item(1'b0, 8'hFE, 24'hFFFFFF, 3'b100, 2'b11, r, lat);
    n_cmp++; if (r !== {1'b0, 8'hFF, 23'h0, 3'b111}) begin n_err++; $display("FAIL overflow: got %h want %h", r, {1'b0, 8'hFF, 23'h0, 3'b111}); end
    run_item(1'b1, 8'hFF, 24'hC00000, 3'b111, 2'b00, r, lat);
    n_cmp++; if (r !== {1'b1, 8'hFF, 23'h400000, 3'b000}) begin n_err++; $display("FAIL special_pass: got %h want %h", r, {1'b1, 8'hFF, 23'h400000, 3'b000}); end
  endtask

  task automatic test_subnormal;
    logic [34:0] r; int lat;
    run_item(1'b0, 8'h00, 24'h7FFFFF, 3'b100, 2'b11, r, lat);
    n_cmp++; if (r !== {1'b0, 8'h01, 23'h0, 3'b101}) begin n_err++; $display("FAIL sub_promote: got %h want %h", r, {1'b0, 8'h01, 23'h0, 3'b101}); end
    run_item(1'b0, 8'h00, 24'h7FFFFF, 3'b100, 2'b01, r, lat);
    n_cmp++; if (r !== {1'b0, 8'h00, 23'h7FFFFF, 3'b100}) begin n_err++; $display("FAIL sub_rdown: got %h want %h", r, {1'b0, 8'h00, 23'h7FFFFF, 3'b100}); end
    run_item(1'b0, 8'h00, 24'h000000, 3'b000, 2'b10, r, lat);
    n_cmp++; if (r !== 35'h0) begin n_err++; $display("FAIL zero: got %h want 0", r); end
  endtask

  task automatic test_back_to_back;
    int sent = 0;
    int got = 0;
    int occ = 0;
    logic saw_block = 1'b0;
    logic acc, emit;
    logic [34:0] exp_v;
    for (int cyc = 1; cyc <= 40 && got < 6; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      if (sent < 6) begin
        drive(1'b0, 8'(16 + sent), 24'h800000 + 24'(2 * sent), (sent % 2 == 1) ? 3'b110 : 3'b000, 2'b10);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      n_cmp++;
      if (in_ready !== ((occ < 2) || out_ready)) begin
        n_err++; $display("FAIL bp_in_ready cyc%0d: got %b want %b", cyc, in_ready, ((occ < 2) || out_ready));
      end
      if (!in_ready) saw_block = 1'b1;
      if (out_valid) begin
        exp_v = {1'b0, 8'(16 + got), 23'(2 * got + (got % 2)), (got % 2 == 1) ? 3'b100 : 3'b000};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL bp_data item%0d cyc%0d: got %h want %h", got, cyc, obs, exp_v); end
      end
      acc  = in_valid && in_ready;
      emit = out_valid && out_ready;
      if (acc) sent++;
      if (emit) got++;
      occ = occ + int'(acc) - int'(emit);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_cmp++; if (got !== 6) begin n_err++; $display("FAIL bp_count: got %0d want 6", got); end
    n_cmp++; if (saw_block !== 1'b1) begin n_err++; $display("FAIL bp_block: in_ready never dropped, got %b want 1", saw_block); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_dup: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midflight;
    logic [34:0] r; int lat;
    out_ready = 1'b0;
    drive(1'b0, 8'h20, 24'h800000, 3'b000, 2'b10);
    in_valid = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 8'h21, 24'h800004, 3'b000, 2'b10);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, in_ready} !== 2'b10) begin n_err++; $display("FAIL rst_full: got valid/ready %b want 10", {out_valid, in_ready}); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_flush: out_valid got %b want 0", out_valid); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_ghost cyc%0d: out_valid got %b want 0", c, out_valid); end
      @(posedge clk); #1;
    end
    run_item(1'b1, 8'h40, 24'hABCDEF, 3'b010, 2'b01, r, lat);
    n_cmp++; if (r !== {1'b1, 8'h40, 23'h2BCDF0, 3'b100}) begin n_err++; $display("FAIL rst_after: got %h want %h", r, {1'b1, 8'h40, 23'h2BCDF0, 3'b100}); end
  endtask

  initial begin
    test_reset();
    test_rte();
    test_carry();
    test_overflow();
    test_subnormal();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
